// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } bcd_state_e;

  // Decimal digits needed to show 2**width-1, i.e. ceil(width*log10(2)).
  // Integer form of log10(2) ~= 0.30103 is exact for any practical width.
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added so the
// following left shift carries into the next decade.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Pre-shift correction; input is always <= 9 so the 4-bit add never wraps.
  always_comb begin
    adjusted = digit;
    if (digit > 4'd4) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter: one shift-and-add-3 iteration per
// clock, saturating overflow flag and leading-zero blanking mask.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  // With enough digits for 2**DATA_W-1 the value can never overflow.
  localparam bit CAN_OVF = (DIGITS < min_digits(DATA_W));
  // Every digit except the units digit; also the reset value of lz_mask.
  localparam logic [DIGITS-1:0] NOT_UNITS = {DIGITS{1'b1}} << 1;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  if (DATA_W < 1 || DIGITS < 1) begin : g_param_check
    $fatal(1, "bcd_seq_conv: DATA_W and DIGITS must both be >= 1");
  end

  bcd_state_e               state_reg, state_next;
  logic [DATA_W-1:0]        shift_reg, shift_next;
  logic [BCD_W-1:0]         digit_reg, digit_next;
  logic                     ovf_acc_reg, ovf_acc_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     valid_reg, valid_next;
  logic [BCD_W-1:0]         bcd_reg, bcd_next;
  logic                     overflow_reg, overflow_next;
  logic [DIGITS-1:0]        lz_mask_reg, lz_mask_next;

  logic [BCD_W-1:0]         adj_digits;
  logic [BCD_W+DATA_W-1:0]  shift_cat;
  logic [BCD_W-1:0]         digit_shifted;
  logic [DATA_W-1:0]        shift_shifted;
  logic                     top_out;
  logic [DIGITS-1:0]        digit_big;
  logic [DIGITS:0]          upper_zero;
  logic [DIGITS-1:0]        lz_final;
  logic                     ovf_final;

  // One correction cell per decade of the running BCD accumulator.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (digit_reg[4*gi +: 4]),
      .adjusted (adj_digits[4*gi +: 4])
    );
  end

  // One iteration: corrected digits and remaining binary shift left as one word.
  assign shift_cat     = {adj_digits, shift_reg} << 1;
  assign digit_shifted = shift_cat[BCD_W+DATA_W-1:DATA_W];
  assign shift_shifted = shift_cat[DATA_W-1:0];
  assign top_out       = adj_digits[BCD_W-1];

  // upper_zero[i] is set when digits i..DIGITS-1 of the new result are all zero.
  assign upper_zero[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_flags
    assign digit_big[gi]  = (digit_shifted[4*gi +: 4] > 4'd9);
    assign upper_zero[gi] = (digit_shifted[4*gi +: 4] == 4'd0) & upper_zero[gi+1];
  end

  assign lz_final  = upper_zero[DIGITS-1:0] & NOT_UNITS;
  assign ovf_final = CAN_OVF & (ovf_acc_reg | top_out | (|digit_big));

  assign ready    = (state_reg == IDLE);
  assign valid    = valid_reg;
  assign bcd      = bcd_reg;
  assign overflow = overflow_reg;
  assign lz_mask  = lz_mask_reg;

  // Next-state logic: load on accept, iterate while converting, publish on the last step.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    digit_next    = digit_reg;
    ovf_acc_next  = ovf_acc_reg;
    cnt_next      = cnt_reg;
    valid_next    = 1'b0;
    bcd_next      = bcd_reg;
    overflow_next = overflow_reg;
    lz_mask_next  = lz_mask_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = CONV;
          shift_next   = data;
          digit_next   = '0;
          ovf_acc_next = 1'b0;
          cnt_next     = CNT_W'(DATA_W);
        end
      end
      CONV: begin
        shift_next   = shift_shifted;
        digit_next   = digit_shifted;
        ovf_acc_next = ovf_acc_reg | top_out;
        cnt_next     = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next    = IDLE;
          valid_next    = 1'b1;
          overflow_next = ovf_final;
          bcd_next      = ovf_final ? ALL_NINES : digit_shifted;
          lz_mask_next  = ovf_final ? '0 : lz_final;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      digit_reg    <= '0;
      ovf_acc_reg  <= 1'b0;
      cnt_reg      <= '0;
      valid_reg    <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
      lz_mask_reg  <= NOT_UNITS;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      digit_reg    <= digit_next;
      ovf_acc_reg  <= ovf_acc_next;
      cnt_reg      <= cnt_next;
      valid_reg    <= valid_next;
      bcd_reg      <= bcd_next;
      overflow_reg <= overflow_next;
      lz_mask_reg  <= lz_mask_next;
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench: two converter instances (16-bit/5-digit and 8-bit/2-digit)
// checked against a decimal-arithmetic reference model.
module tb_bcd_seq_conv;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [31:0] lz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic [15:0] data_a = '0;
  logic        ready_a, valid_a, ovf_a;
  logic [19:0] bcd_a;
  logic [4:0]  lz_a;
  logic        start_b = 1'b0;
  logic [7:0]  data_b = '0;
  logic        ready_b, valid_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [1:0]  lz_b;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready_at_a = 0;
  int   ready_at_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  bcd_seq_conv #(.DATA_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a), .ready(ready_a),
    .valid(valid_a), .bcd(bcd_a), .overflow(ovf_a), .lz_mask(lz_a)
  );

  bcd_seq_conv #(.DATA_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b), .ready(ready_b),
    .valid(valid_b), .bcd(bcd_b), .overflow(ovf_b), .lz_mask(lz_b)
  );

  always #10 clk = ~clk;

  // Cycle number: count of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input int val);
    tests++;
    fails++;
    $display("FAIL %s: value %0d (cycle %0d)", name, val, cyc);
  endtask

  // Reference: decimal digits by division, saturation when value >= 10**digits.
  function automatic exp_t model(input int unsigned v, input int digits, input int vcyc);
    exp_t e;
    longint unsigned lim = 1;
    longint unsigned p = 1;
    e.bcd = '0;
    e.ovf = 1'b0;
    e.lz  = '0;
    e.cyc = vcyc;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (v >= lim) begin
      e.ovf = 1'b1;
      for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'd9;
    end else begin
      for (int i = 0; i < digits; i++) begin
        e.bcd[4*i +: 4] = 4'((v / p) % 10);
        if (i > 0 && (v / p) == 0) e.lz[i] = 1'b1;
        p = p * 10;
      end
    end
    return e;
  endfunction

  // Drive one start pulse now; the model decides whether it is accepted.
  task automatic issue(input bit sel_b, input int unsigned v);
    int  c;
    int  dw;
    bit  acc;
    c   = cyc;
    dw  = sel_b ? 8 : 16;
    acc = (c >= (sel_b ? ready_at_b : ready_at_a));
    if (sel_b) begin
      check("ready_b", ready_b, acc);
      start_b = 1'b1;
      data_b  = 8'(v);
      if (acc) begin
        qb.push_back(model(v, 2, c + 1 + dw));
        ready_at_b = c + 1 + dw;
      end
    end else begin
      check("ready_a", ready_a, acc);
      start_a = 1'b1;
      data_a  = 16'(v);
      if (acc) begin
        qa.push_back(model(v, 5, c + 1 + dw));
        ready_at_a = c + 1 + dw;
      end
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_ready(input bit sel_b);
    while (cyc < (sel_b ? ready_at_b : ready_at_a)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic conv(input bit sel_b, input int unsigned v);
    wait_ready(sel_b);
    issue(sel_b, v);
  endtask

  task automatic check_reset_state();
    check("rst_ready_a", ready_a, 1);
    check("rst_valid_a", valid_a, 0);
    check("rst_bcd_a", bcd_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_lz_a", lz_a, 5'b11110);
    check("rst_ready_b", ready_b, 1);
    check("rst_valid_b", valid_b, 0);
    check("rst_bcd_b", bcd_b, 0);
    check("rst_lz_b", lz_b, 2'b10);
  endtask

  // Monitor for the 16-bit instance: pop on valid, flag late or stray results.
  always @(negedge clk) begin
    if (qa.size() > 0 && cyc > qa[0].cyc) begin
      note_fail("missing_valid_a", qa[0].cyc);
      void'(qa.pop_front());
    end
    if (valid_a) begin
      if (qa.size() == 0) begin
        note_fail("unexpected_valid_a", bcd_a);
      end else begin
        ea = qa.pop_front();
        check("latency_a", cyc, ea.cyc);
        check("bcd_a", bcd_a, ea.bcd);
        check("ovf_a", ovf_a, ea.ovf);
        check("lz_a", lz_a, ea.lz);
      end
    end
  end

  // Monitor for the 8-bit/2-digit instance.
  always @(negedge clk) begin
    if (qb.size() > 0 && cyc > qb[0].cyc) begin
      note_fail("missing_valid_b", qb[0].cyc);
      void'(qb.pop_front());
    end
    if (valid_b) begin
      if (qb.size() == 0) begin
        note_fail("unexpected_valid_b", bcd_b);
      end else begin
        eb = qb.pop_front();
        check("latency_b", cyc, eb.cyc);
        check("bcd_b", bcd_b, eb.bcd);
        check("ovf_b", ovf_b, eb.ovf);
        check("lz_b", lz_b, eb.lz);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero, full scale, then a back-to-back start in the valid cycle.
    conv(0, 0);
    conv(0, 65535);
    conv(0, 12345);

    // Start while busy is ignored; restart in the valid cycle is accepted.
    conv(0, 42);
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(0, 7);
    conv(0, 7);

    // Boundaries and random values for the 16-bit instance.
    conv(0, 9);
    conv(0, 10);
    conv(0, 10000);
    conv(0, 99999 & 16'hffff);
    for (int i = 0; i < 30; i++) conv(0, $urandom_range(0, 65535));

    // Reset at edge k+5 aborts a conversion without a valid.
    wait_ready(0);
    wait_ready(1);
    issue(0, 54321);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    qa.delete();
    ready_at_a = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_reset_state();
    repeat (20) begin
      @(posedge clk); #1;
    end

    // Overflow and saturation on the 2-digit instance.
    conv(1, 255);
    conv(1, 99);
    conv(1, 100);
    conv(1, 0);
    conv(1, 9);
    conv(1, 10);
    for (int i = 0; i < 40; i++) conv(1, $urandom_range(0, 255));

    // Interleaved traffic on both instances.
    for (int i = 0; i < 10; i++) begin
      conv(0, $urandom_range(0, 65535));
      conv(1, $urandom_range(0, 255));
    end

    // Drain and confirm every expected result was seen.
    wait_ready(0);
    wait_ready(1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
